timer_cnt_ctrl: RTL and testbench

TIMER_CNT_CTRL -- requirements
Module: timer_cnt_ctrl

---
 rtl/timer_pkg.sv | 12 +
 rtl/edge_det.sv | 21 ++
 rtl/timer_cnt_ctrl.sv | 87 ++++++++
 tb/tb_timer_cnt_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer counter control block: FSM encoding and default width.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        COUNT = 2'b10
    } state_t;

    localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a pclk-synchronous input; rise is high for one pclk cycle per edge.
module edge_det (
    input  logic pclk,
    input  logic presetn,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/timer_cnt_ctrl.sv
// Up/down timer counter with load, sticky wrap flags and a registered interrupt.
module timer_cnt_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             clk_in,
    input  logic             en,
    input  logic             load,
    input  logic             up_dn,
    input  logic [CNT_W-1:0] tdr,
    input  logic             ovf_clr,
    input  logic             udf_clr,
    input  logic             ovf_ie,
    input  logic             udf_ie,
    output logic [CNT_W-1:0] cnt,
    output logic             tick,
    output logic             ovf,
    output logic             udf,
    output logic             busy,
    output logic             tmr_int
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t state;
    logic   count_ev;
    logic   wrap_up;
    logic   wrap_dn;

    edge_det u_edge_det (
        .pclk    (pclk),
        .presetn (presetn),
        .d       (clk_in),
        .rise    (tick)
    );

    // A tick only advances the counter when COUNT is held (en=1) and no load competes.
    always_comb begin
        count_ev = 1'b0;
        wrap_up  = 1'b0;
        wrap_dn  = 1'b0;
        if (state == COUNT && en && !load && tick) begin
            count_ev = 1'b1;
            wrap_up  = up_dn  && (cnt == '1);
            wrap_dn  = !up_dn && (cnt == '0);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            cnt     <= '0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
            tmr_int <= 1'b0;
        end else begin
            if (load) begin
                state <= LOAD;
                cnt   <= tdr;
            end else begin
                case (state)
                    IDLE:    state <= en ? COUNT : IDLE;
                    LOAD:    state <= en ? COUNT : IDLE;
                    COUNT: begin
                        if (!en) begin
                            state <= IDLE;
                        end else if (count_ev) begin
                            cnt <= up_dn ? cnt + ONE : cnt - ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // Set beats a simultaneous clear.
            ovf     <= wrap_up | (ovf & ~ovf_clr);
            udf     <= wrap_dn | (udf & ~udf_clr);
            tmr_int <= (ovf & ovf_ie) | (udf & udf_ie);
        end
    end

    assign busy = (state == COUNT);

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Randomized and directed bench for timer_cnt_ctrl against a cycle-level behavioural model.
module tb_timer_cnt_ctrl;

    localparam int W    = 8;
    localparam int MODV = 256;

    logic         pclk = 1'b0;
    logic         presetn = 1'b0;
    logic         clk_in = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic         up_dn = 1'b1;
    logic [W-1:0] tdr = '0;
    logic         ovf_clr = 1'b0;
    logic         udf_clr = 1'b0;
    logic         ovf_ie = 1'b0;
    logic         udf_ie = 1'b0;
    logic [W-1:0] cnt;
    logic         tick;
    logic         ovf;
    logic         udf;
    logic         busy;
    logic         tmr_int;

    int checks = 0;
    int failures = 0;

    // Behavioural model: counter as plain integer, activity described by two booleans.
    int m_cnt;
    bit m_counting;
    bit m_loading;
    bit m_prev_clk;
    bit m_ovf;
    bit m_udf;
    bit m_int;

    timer_cnt_ctrl #(.CNT_W(W)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .clk_in  (clk_in),
        .en      (en),
        .load    (load),
        .up_dn   (up_dn),
        .tdr     (tdr),
        .ovf_clr (ovf_clr),
        .udf_clr (udf_clr),
        .ovf_ie  (ovf_ie),
        .udf_ie  (udf_ie),
        .cnt     (cnt),
        .tick    (tick),
        .ovf     (ovf),
        .udf     (udf),
        .busy    (busy),
        .tmr_int (tmr_int)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_counting = 0; m_loading = 0; m_prev_clk = 0;
        m_ovf = 0; m_udf = 0; m_int = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_cnt"}, 32'(cnt), 32'(m_cnt));
        check({tag, "_busy"}, 32'(busy), 32'(m_counting));
        check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, "_udf"}, 32'(udf), 32'(m_udf));
        check({tag, "_int"}, 32'(tmr_int), 32'(m_int));
    endtask

    // One pclk cycle with the inputs currently driven; strobes are dropped after the edge.
    task automatic step(input string tag);
        bit t, set_o, set_u;
        #1;
        t = clk_in && !m_prev_clk;
        check({tag, "_tick"}, 32'(tick), 32'(t));
        set_o = 0; set_u = 0;
        m_int = (m_ovf && ovf_ie) || (m_udf && udf_ie);
        if (load) begin
            m_cnt = int'(tdr); m_loading = 1; m_counting = 0;
        end else if (m_loading) begin
            m_loading = 0; m_counting = en;
        end else if (m_counting) begin
            if (!en) m_counting = 0;
            else if (t) begin
                if (up_dn) begin
                    set_o = (m_cnt + 1 >= MODV);
                    m_cnt = (m_cnt + 1) % MODV;
                end else begin
                    set_u = (m_cnt - 1 < 0);
                    m_cnt = (m_cnt - 1 + MODV) % MODV;
                end
            end
        end else begin
            m_counting = en;
        end
        m_ovf = set_o || (m_ovf && !ovf_clr);
        m_udf = set_u || (m_udf && !udf_clr);
        m_prev_clk = clk_in;
        @(posedge pclk);
        #1;
        load = 0; ovf_clr = 0; udf_clr = 0;
        check_all(tag);
    endtask

    // Produce one clk_in rising edge spread over two pclk cycles.
    task automatic edge_pair(input string tag);
        clk_in = 1; step(tag);
        clk_in = 0; step(tag);
    endtask

    task automatic do_load(input logic [W-1:0] v, input string tag);
        tdr = v; load = 1; step(tag);
        step(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        check_all("reset");
        @(negedge pclk);
        presetn = 1;
        #1;
        check("rst_rel_tick", 32'(tick), 32'(0));

        // Overflow from FD with interrupt one cycle after the flag.
        en = 1; up_dn = 1; ovf_ie = 1;
        do_load(8'hFD, "ovf_load");
        clk_in = 1; step("ovf_e1");
        check("ovf_fe", 32'(cnt), 32'h0FE);
        clk_in = 0; step("ovf_e1b");
        clk_in = 1; step("ovf_e2");
        check("ovf_ff", 32'(cnt), 32'h0FF);
        clk_in = 0; step("ovf_e2b");
        clk_in = 1; step("ovf_e3");
        check("ovf_wrap_cnt", 32'(cnt), 32'h000);
        check("ovf_set", 32'(ovf), 32'h1);
        check("ovf_int_late", 32'(tmr_int), 32'h0);
        clk_in = 0; step("ovf_e3b");
        check("ovf_int", 32'(tmr_int), 32'h1);
        ovf_clr = 1; step("ovf_clr");
        step("ovf_clr2");
        check("ovf_int_drop", 32'(tmr_int), 32'h0);

        // Underflow from 01.
        up_dn = 0;
        do_load(8'h01, "udf_load");
        edge_pair("udf_e1");
        check("udf_00", 32'(cnt), 32'h000);
        edge_pair("udf_e2");
        check("udf_ff", 32'(cnt), 32'h0FF);
        check("udf_set", 32'(udf), 32'h1);
        check("udf_no_ovf", 32'(ovf), 32'h0);
        udf_clr = 1; step("udf_clr");

        // Load coincides with a tick at FF: load wins, no flag.
        up_dn = 1;
        do_load(8'hFF, "col_load");
        tdr = 8'h10; load = 1; clk_in = 1; step("col");
        check("col_cnt", 32'(cnt), 32'h010);
        check("col_ovf", 32'(ovf), 32'h0);
        clk_in = 0; step("col_b");

        // Clear in the same cycle as a wrap: set wins, then clears next cycle.
        do_load(8'hFF, "sc_load");
        clk_in = 1; ovf_clr = 1; step("sc_wrap");
        check("sc_set_wins", 32'(ovf), 32'h1);
        clk_in = 0; ovf_clr = 1; step("sc_clr");
        check("sc_cleared", 32'(ovf), 32'h0);

        // Pause at 05 and resume.
        do_load(8'h03, "pause_load");
        edge_pair("pause_e1");
        edge_pair("pause_e2");
        en = 0; step("pause_off");
        repeat (3) edge_pair("paused");
        check("pause_hold", 32'(cnt), 32'h005);
        check("pause_busy", 32'(busy), 32'h0);
        en = 1; step("resume");
        edge_pair("resume_e");
        check("resume_cnt", 32'(cnt), 32'h006);

        // Asynchronous reset mid-count at 7A.
        do_load(8'h79, "rst_load");
        edge_pair("rst_e");
        check("rst_pre", 32'(cnt), 32'h07A);
        #2 presetn = 0;
        #1;
        model_reset();
        check("rst_cnt", 32'(cnt), 32'h000);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge pclk);
        en = 0; clk_in = 0; presetn = 1;
        #1;
        check("rst_tick", 32'(tick), 32'h0);
        repeat (3) edge_pair("rst_idle");
        check("rst_idle_cnt", 32'(cnt), 32'h000);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            load    = ($urandom_range(0, 29) == 0);
            clk_in  = $urandom_range(0, 1);
            up_dn   = ($urandom_range(0, 63) == 0) ? ~up_dn : up_dn;
            ovf_clr = ($urandom_range(0, 19) == 0);
            udf_clr = ($urandom_range(0, 19) == 0);
            ovf_ie  = $urandom_range(0, 1);
            udf_ie  = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       tdr = 8'hFE;
                1:       tdr = 8'h01;
                default: tdr = W'($urandom);
            endcase
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
